// File: rtl/piso_pkg.sv
// Shared state encoding and elaboration-time sizing helpers for the PISO serializer.
// Latency: not applicable (types and constant functions only).
// Backpressure: not applicable.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } piso_state_t;

  // Ceiling log2; clog2(1) = 0, callers clamp to a minimum width themselves.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  // Number of serial beats needed to drain one parallel word.
  function automatic int beats(input int data_w, input int lanes);
    return (lanes > 0) ? (data_w / lanes) : 1;
  endfunction

  // Beat counter width: enough to hold BEATS-1, never narrower than one bit.
  function automatic int cnt_width(input int n_beats);
    int w;
    w = clog2(n_beats);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_beat_counter.sv
// Beat index counter for one word in flight; flags the final beat of the word.
// Latency: terminal is combinational from the registered count.
// Backpressure: advances only when en (beat handshake) is high; load restarts at beat 0.
module piso_beat_counter
  import piso_pkg::*;
#(
  parameter int BEATS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic terminal
);

  localparam int               CNT_W = cnt_width(BEATS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0] count;

  // Count handshaked beats; a new word (load) wins over an advance in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

  // Final beat of the word: with a single beat per word every beat is final.
  always_comb begin
    terminal = (count == LAST);
  end

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in serial-out converter: one DATA_W word out as DATA_W/LANES beats, LSB- or MSB-first.
// Latency: first beat valid the cycle after the word is accepted; back-to-back words with no bubble.
// Backpressure: m_ready low freezes the presented beat; s_ready only in IDLE or on the last-beat handshake.
module piso_stream_serializer
  import piso_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_msb_first,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [LANES-1:0]  m_data,
  output logic              m_last,
  output logic              busy
);

  localparam int BEATS = beats(DATA_W, LANES);

  generate
    if ((LANES < 1) || (LANES > DATA_W) || ((DATA_W % LANES) != 0)) begin : g_bad_geometry
      $error("piso_stream_serializer: DATA_W (%0d) must be a positive multiple of LANES (%0d)",
             DATA_W, LANES);
    end
  endgenerate

  piso_state_t       state;
  piso_state_t       state_nxt;
  logic [DATA_W-1:0] sreg;
  logic              msb_first_q;
  logic              s_fire;
  logic              m_fire;
  logic              terminal;

  piso_beat_counter #(
    .BEATS (BEATS)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (s_fire),
    .en       (m_fire),
    .terminal (terminal)
  );

  // Handshake qualifiers; s_ready never looks at s_valid so upstream may wait on it.
  always_comb begin
    m_fire  = m_valid && m_ready;
    s_ready = (state == ST_IDLE) || (m_fire && m_last);
    s_fire  = s_valid && s_ready;
  end

  // FSM state register; reset drops any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a word accepted on the final beat keeps us in SHIFT with no bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (s_fire) begin
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (m_fire && m_last && !s_fire) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: a beat is presented for the whole of SHIFT, even while stalled.
  always_comb begin
    m_valid = 1'b0;
    busy    = 1'b0;
    m_last  = 1'b0;
    case (state)
      ST_SHIFT: begin
        m_valid = 1'b1;
        busy    = 1'b1;
        m_last  = terminal;
      end
      default: begin
        m_valid = 1'b0;
      end
    endcase
  end

  // Shift register and order flag: load on accept, shift toward the output end on each beat.
  // Zero fill means the register is empty (all zero) once a word has fully drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg        <= '0;
      msb_first_q <= 1'b0;
    end else if (s_fire) begin
      sreg        <= s_data;
      msb_first_q <= s_msb_first;
    end else if (m_fire) begin
      if (msb_first_q) begin
        sreg <= sreg << LANES;
      end else begin
        sreg <= sreg >> LANES;
      end
    end
  end

  // Direction mux: pick the top or bottom slice; lane i stays bit i of the slice.
  always_comb begin
    if (msb_first_q) begin
      m_data = sreg[DATA_W-1 -: LANES];
    end else begin
      m_data = sreg[LANES-1:0];
    end
  end

  // A stalled beat must stay presented unchanged until it is taken.
  a_stall_hold : assert property (@(posedge clk) disable iff (rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

  // Upstream is only offered a slot in SHIFT when the final beat leaves this cycle.
  a_ready_in_shift : assert property (@(posedge clk) disable iff (rst)
    (s_ready && (state == ST_SHIFT)) |-> (m_fire && m_last));

endmodule
